imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction-word count (power of two); IDX_W = log2(DEPTH).
REQ-002 SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, byte address of word 0.
REQ-003 SHALL have parameter LAT, default 2, request-to-response latency in cycles, legal range 1..8.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-006 SHALL have ports req_valid (input, 1) and req_ready (output, 1), the fetch-request handshake.
REQ-007 SHALL have port req_addr, input, 64, the fetch PC (byte address).
REQ-008 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1), the response handshake.
REQ-009 SHALL have port resp_inst, output, 32, the fetched instruction.
REQ-010 SHALL have port resp_err, output, 1, the access-fault flag qualified by resp_valid.
REQ-011 SHALL have ports ld_en (input, 1), ld_idx (input, IDX_W) and ld_data (input, 32), the program-load write port.
REQ-012 SHALL have port ebreak_seen, output, 1, sticky flag set when 32'h00100073 is returned.

Function
REQ-013 SHALL use FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE; at most one request outstanding.
REQ-014 SHALL accept on req_valid&&req_ready in IDLE: latch req_addr, load counter with LAT-1, go to WAIT.
REQ-015 SHALL decrement the counter in WAIT; at counter==0 (capture cycle) register data/err and go to RESP, so resp_valid rises exactly LAT cycles after the accept edge.
REQ-016 SHALL hold resp_valid, resp_inst and resp_err stable in RESP until resp_ready=1, then go to IDLE; no new accept in the same cycle (minimum 1-cycle gap).
REQ-017 SHALL index the memory with (addr-BASE_ADDR)>>2, using 64-bit unsigned arithmetic.
REQ-018 SHALL flag out of range when addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH: resp_err=1 and resp_inst=32'h0000_0013 (NOP).
REQ-019 SHALL write mem[ld_idx]=ld_data on any cycle with ld_en=1, in every state.
REQ-020 SHALL return the new ld_data when a load writes the word being read in the capture cycle (write-first).
REQ-021 SHALL set ebreak_seen on the RESP entry edge when resp_err=0 and the captured word equals 32'h00100073; it SHALL stay set until reset.

Reset
REQ-022 SHALL, with rst=0 at a clock edge, force state=IDLE, counter=0, resp_valid=0, resp_inst=0, resp_err=0 and ebreak_seen=0.
REQ-023 SHALL drop any in-flight request on reset mid-operation, with no response produced afterward.
REQ-024 SHALL NOT reset memory contents; ld_en SHALL still write while rst=0.

Configuration
REQ-025 SHALL, with IMEM_MISALIGN_CHK_EN defined, also treat req_addr[1:0]!=0 as a fault (resp_err=1, NOP returned).
REQ-026 SHALL, with IMEM_MISALIGN_CHK_EN undefined, ignore req_addr[1:0] and return the containing aligned word.

Structure
REQ-027 SHALL take from shared package imem_pkg: the state enum, NOP_INST=32'h0000_0013 and EBREAK_INST=32'h00100073.
REQ-028 SHALL contain sub-module imem_array, with a synchronous write port and a combinational read port, holding DEPTH x 32 words.

Verification
REQ-029 SHALL cover the basic fetch: load idx0=32'h00000513, request 0x80000000 at cycle T (LAT=2) -> resp_valid at T+2 with inst 0x00000513 and err=0.
REQ-030 SHALL cover backpressure: hold resp_ready=0 for 5 cycles -> resp stable and req_ready=0 throughout; accept possible 1 cycle after the resp_ready handshake.
REQ-031 SHALL cover out-of-range fetches: request 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> err=1, inst 0x00000013.
REQ-032 SHALL cover misalignment: request 0x80000002 -> err=1 with the macro defined; inst of idx0 with err=0 without it.
REQ-033 SHALL cover ebreak and reset: fetch a word holding 0x00100073 -> ebreak_seen=1 after RESP entry; rst=0 mid-WAIT -> resp_valid stays 0 and ebreak_seen clears.
REQ-034 SHALL cover write-first: ld_en to the target idx in the capture cycle with 0xDEADBEEF -> resp_inst=0xDEADBEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder: the FSM state
// encoding, the counter width that covers the legal latency range, and the
// two instruction encodings the responder treats specially.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package imem_pkg;

    // IDLE: ready for a fetch; WAIT: counting down latency; RESP: holding answer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latency counter holds LAT-1, and LAT is at most 8.
    localparam int unsigned CNT_W = 3;

    localparam logic [31:0] NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/imem_responder_if.sv
// -----------------------------------------------------------------------------
// imem_responder_if
// Fetch request / response bus between an instruction fetcher (master) and
// the instruction memory responder (slave).
//   req_valid/req_ready : request handshake, req_addr = fetch PC (byte address)
//   resp_valid/resp_ready: response handshake
//   resp_inst            : fetched instruction word
//   resp_err             : access fault, qualified by resp_valid
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface imem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/imem_array.sv
// -----------------------------------------------------------------------------
// imem_array
// DEPTH x 32 instruction storage. Synchronous write, combinational read with
// write-first forwarding: a write to the word being read in the same cycle
// shows its new data on the read port immediately.
// Ports:
//   clk                : clock
//   i_wr_en/i_wr_idx/i_wr_data : write port
//   i_rd_idx/o_rd_data : combinational read port
// Contents are not reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_array #(
    parameter  int unsigned DEPTH = 1024,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [DEPTH];

    // Program-load write; independent of reset so code can be loaded under reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read with forwarding of a same-cycle write to the same word.
    always_comb begin
        if (i_wr_en && (i_wr_idx == i_rd_idx)) begin
            o_rd_data = i_wr_data;
        end else begin
            o_rd_data = r_mem[i_rd_idx];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Fixed-latency instruction memory responder. One fetch may be outstanding;
// the response appears LAT cycles after the accept edge and is held until the
// requester takes it. Addresses outside [BASE_ADDR, BASE_ADDR+4*DEPTH) return
// a NOP with resp_err set. A sticky flag records any returned EBREAK.
// Ports:
//   clk          : clock, all state on rising edge
//   rst          : synchronous active-low reset
//   bus          : imem_responder_if.slave (fetch request/response handshakes)
//   ld_en/ld_idx/ld_data : program-load write port, active in every state
//   ebreak_seen  : sticky, set when an EBREAK word is returned without fault
// Build option:
//   IMEM_MISALIGN_CHK_EN : when defined, req_addr[1:0] != 0 is a fault;
//                          otherwise the low address bits are ignored.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module imem_responder
    import imem_pkg::*;
#(
    parameter  int unsigned DEPTH     = 1024,
    parameter  logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
    parameter  int unsigned LAT       = 2,
    localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    imem_responder_if.slave  bus,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [31:0]      ld_data,
    output logic             ebreak_seen
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);
    localparam logic [63:0]      SPAN     = 64'(DEPTH) * 64'd4;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_addr;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [31:0]      r_resp_inst;
    logic             r_resp_err;
    logic             r_ebreak;

    logic [63:0]      w_offset;
    logic             w_in_range;
    logic             w_misalign;
    logic             w_fault;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rd_data;
    logic [31:0]      w_cap_inst;

    // Offset form of the range test avoids overflow of BASE_ADDR + 4*DEPTH.
    assign w_offset   = r_addr - BASE_ADDR;
    assign w_in_range = (r_addr >= BASE_ADDR) && (w_offset < SPAN);
    assign w_idx      = w_offset[IDX_W+1:2];

`ifdef IMEM_MISALIGN_CHK_EN
    assign w_misalign = (r_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = (!w_in_range) || w_misalign;

    imem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (ld_en),
        .i_wr_idx  (ld_idx),
        .i_wr_data (ld_data),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data)
    );

    // Word to capture: NOP on any fault, otherwise the (forwarded) memory word.
    always_comb begin
        if (w_fault) begin
            w_cap_inst = NOP_INST;
        end else begin
            w_cap_inst = w_rd_data;
        end
    end

    // Request/response FSM with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_addr       <= 64'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_inst  <= 32'd0;
            r_resp_err   <= 1'b0;
            r_ebreak     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // req_ready is 1 in IDLE, so req_valid alone is an accept.
                    if (bus.req_valid) begin
                        r_addr      <= bus.req_addr;
                        r_cnt       <= CNT_LOAD;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp_valid <= 1'b1;
                        r_resp_inst  <= w_cap_inst;
                        r_resp_err   <= w_fault;
                        if (!w_fault && (w_rd_data == EBREAK_INST)) begin
                            r_ebreak <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Return to IDLE only; the next accept happens a cycle later.
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_inst  = r_resp_inst;
    assign bus.resp_err   = r_resp_err;
    assign ebreak_seen    = r_ebreak;

endmodule

// File: tb/tb_imem_responder.sv
// -----------------------------------------------------------------------------
// tb_imem_responder
// Directed bench for imem_responder with default parameters (DEPTH=1024,
// BASE_ADDR=0x80000000, LAT=2). Inputs change and outputs are sampled 1 ns
// after each rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_responder;

    logic       clk;
    logic       rst;
    logic       ld_en;
    logic [9:0] ld_idx;
    logic [31:0] ld_data;
    logic       ebreak_seen;

    int n_checks;
    int n_errors;

    imem_responder_if bus ();

    imem_responder u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .ld_en       (ld_en),
        .ld_idx      (ld_idx),
        .ld_data     (ld_data),
        .ebreak_seen (ebreak_seen)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] data);
        ld_en   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        tick();
        ld_en   = 1'b0;
    endtask

    // One complete fetch with immediate response acceptance.
    task automatic fetch(input string tag, input logic [63:0] addr,
                         input logic [31:0] exp_inst, input logic exp_err);
        check({tag, "_rdy"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        tick();                                   // accept edge
        bus.req_valid = 1'b0;
        check({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
        check({tag, "_v0"}, 64'(bus.resp_valid), 64'd0);
        tick();                                   // accept + 1
        check({tag, "_v1"}, 64'(bus.resp_valid), 64'd0);
        tick();                                   // accept + 2
        check({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
        check({tag, "_inst"}, 64'(bus.resp_inst), 64'(exp_inst));
        check({tag, "_err"}, 64'(bus.resp_err), 64'(exp_err));
        bus.resp_ready = 1'b1;
        tick();                                   // response handshake
        bus.resp_ready = 1'b0;
        check({tag, "_done"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_idle"}, 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b0;
        ld_en          = 1'b0;
        ld_idx         = 10'd0;
        ld_data        = 32'd0;
        bus.req_valid  = 1'b0;
        bus.req_addr   = 64'd0;
        bus.resp_ready = 1'b0;

        // Program load while held in reset.
        load(10'd0,    32'h0000_0513);
        load(10'd1,    32'h0010_0073);
        load(10'd2,    32'h2222_2222);
        load(10'd5,    32'h1111_1111);
        load(10'd1023, 32'hCAFE_F00D);
        tick();

        check("rst_valid",  64'(bus.resp_valid), 64'd0);
        check("rst_inst",   64'(bus.resp_inst),  64'd0);
        check("rst_err",    64'(bus.resp_err),   64'd0);
        check("rst_ebreak", 64'(ebreak_seen),    64'd0);
        check("rst_ready",  64'(bus.req_ready),  64'd1);
        rst = 1'b1;
        tick();

        // Basic fetch of word 0.
        fetch("basic", 64'h0000_0000_8000_0000, 32'h0000_0513, 1'b0);

        // Backpressure: response held 5 cycles, new request attempts ignored.
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h0000_0000_8000_0014;
        tick();
        bus.req_addr  = 64'h0000_0000_8000_0000;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_inst",  64'(bus.resp_inst),  64'h1111_1111);
            check("bp_ready", 64'(bus.req_ready),  64'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();                                   // handshake; no accept here
        bus.resp_ready = 1'b0;
        check("bp_gap_valid", 64'(bus.resp_valid), 64'd0);
        check("bp_gap_ready", 64'(bus.req_ready),  64'd1);
        tick();                                   // accept of the pending request
        bus.req_valid = 1'b0;
        check("bp_acc_ready", 64'(bus.req_ready), 64'd0);
        tick();
        tick();
        check("bp2_valid", 64'(bus.resp_valid), 64'd1);
        check("bp2_inst",  64'(bus.resp_inst),  64'h0000_0513);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // Range boundaries.
        fetch("below", 64'h0000_0000_7FFF_FFFC, 32'h0000_0013, 1'b1);
        fetch("above", 64'h0000_0000_8000_1000, 32'h0000_0013, 1'b1);
        fetch("last",  64'h0000_0000_8000_0FFC, 32'hCAFE_F00D, 1'b0);
        fetch("huge",  64'hFFFF_FFFF_8000_0000, 32'h0000_0013, 1'b1);

        // Misaligned PC.
`ifdef IMEM_MISALIGN_CHK_EN
        fetch("misal", 64'h0000_0000_8000_0002, 32'h0000_0013, 1'b1);
`else
        fetch("misal", 64'h0000_0000_8000_0002, 32'h0000_0513, 1'b0);
`endif
        check("no_ebreak", 64'(ebreak_seen), 64'd0);

        // Write-first: overwrite the target word during the capture cycle.
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h0000_0000_8000_0008;
        tick();
        bus.req_valid = 1'b0;
        tick();
        ld_en   = 1'b1;
        ld_idx  = 10'd2;
        ld_data = 32'hDEAD_BEEF;
        tick();
        ld_en   = 1'b0;
        check("wf_valid", 64'(bus.resp_valid), 64'd1);
        check("wf_inst",  64'(bus.resp_inst),  64'hDEAD_BEEF);
        check("wf_err",   64'(bus.resp_err),   64'd0);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;

        // EBREAK fetch sets the sticky flag on RESP entry.
        fetch("ebreak", 64'h0000_0000_8000_0004, 32'h0010_0073, 1'b0);
        check("ebreak_set", 64'(ebreak_seen), 64'd1);
        fetch("ebreak_stk", 64'h0000_0000_8000_0000, 32'h0000_0513, 1'b0);
        check("ebreak_hold", 64'(ebreak_seen), 64'd1);

        // Reset in WAIT drops the request and clears the flag.
        bus.req_valid = 1'b1;
        bus.req_addr  = 64'h0000_0000_8000_0000;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("mid_ebreak", 64'(ebreak_seen),   64'd0);
        check("mid_ready",  64'(bus.req_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("mid_valid", 64'(bus.resp_valid), 64'd0);
            tick();
        end

        // Memory survives reset; normal operation resumes.
        fetch("post", 64'h0000_0000_8000_0008, 32'hDEAD_BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
